// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus (CDB) arbiter slice.
//
// Contents:
//   ROB_ID_W        - width of a reorder-buffer tag (tag 0 means "no tag")
//   CDB_FIFO_DEPTH  - default number of entries per source result FIFO
//   CDB_SRC_ALU/LSB - encoding of the cdb_src broadcast field
package cdb_arbiter_pkg;

    localparam int   ROB_ID_W       = 5;
    localparam int   CDB_FIFO_DEPTH = 4;

    localparam logic CDB_SRC_ALU    = 1'b0;
    localparam logic CDB_SRC_LSB    = 1'b1;

endpackage

// File: rtl/cdb_result_fifo.sv
// Synchronous result FIFO, one instance per CDB producer.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   flush        - clears the FIFO in the same way as rst
//   push         - write push_data at the tail (dropped if full and not popping)
//   pop          - retire the head entry (ignored when empty)
//   push_data    - entry to write
//   head         - current head entry (meaningless when count is 0)
//   count        - number of stored entries, 0..DEPTH
module cdb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             full;
    logic             empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A push into a full FIFO is only accepted when the head leaves in the
    // same edge; otherwise the entry is silently dropped.
    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares one registered broadcast bus between the
// ALU and the load/store buffer. Each producer feeds a small result FIFO and
// a round-robin arbiter drains one result per cycle onto the CDB.
//
// Build option:
//   CDB_BYPASS_EN - when defined, an empty FIFO forwards the incoming result
//                   straight to the arbiter (1-cycle latency); otherwise every
//                   result is queued first (2-cycle minimum latency).
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   rdy                           - global enable; low freezes all state
//   flush                         - wrong-path recovery, clears everything
//   alu_valid/alu_res/alu_rob_id  - ALU result input (tag 0 ignored)
//   lsb_valid/lsb_res/lsb_rob_id  - LSB result input (tag 0 ignored)
//   alu_afull, lsb_afull          - almost-full backpressure to producers
//   cdb_valid/cdb_res/cdb_rob_id  - registered broadcast
//   cdb_src                       - broadcast source, 0 = ALU, 1 = LSB
module cdb_arbiter #(
    parameter int FIFO_DEPTH = cdb_arbiter_pkg::CDB_FIFO_DEPTH,
    parameter int ROB_ID_W   = cdb_arbiter_pkg::ROB_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [31:0]         alu_res,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic                lsb_valid,
    input  logic [31:0]         lsb_res,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    output logic                alu_afull,
    output logic                lsb_afull,
    output logic                cdb_valid,
    output logic [31:0]         cdb_res,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic                cdb_src
);

    import cdb_arbiter_pkg::*;

    localparam int W     = 32 + ROB_ID_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [W-1:0]        alu_in_data, lsb_in_data;
    logic [W-1:0]        alu_head, lsb_head;
    logic [CNT_W-1:0]    alu_count, lsb_count;
    logic                alu_in_ok, lsb_in_ok;
    logic                alu_empty, lsb_empty;
    logic                alu_cand, lsb_cand;
    logic [W-1:0]        alu_cand_data, lsb_cand_data;
    logic                alu_grant, lsb_grant;
    logic                alu_push, lsb_push;
    logic                alu_pop, lsb_pop;
    logic [W-1:0]        win_data;

    logic                rr_q, rr_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [31:0]         cdb_res_q, cdb_res_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic                cdb_src_q, cdb_src_d;

    assign alu_in_ok   = alu_valid && (alu_rob_id != '0);
    assign lsb_in_ok   = lsb_valid && (lsb_rob_id != '0);
    assign alu_in_data = {alu_res, alu_rob_id};
    assign lsb_in_data = {lsb_res, lsb_rob_id};
    assign alu_empty   = (alu_count == '0);
    assign lsb_empty   = (lsb_count == '0);

    // The head always has precedence over the incoming result so that each
    // source broadcasts in arrival order.
`ifdef CDB_BYPASS_EN
    assign alu_cand      = !alu_empty || alu_in_ok;
    assign lsb_cand      = !lsb_empty || lsb_in_ok;
    assign alu_cand_data = alu_empty ? alu_in_data : alu_head;
    assign lsb_cand_data = lsb_empty ? lsb_in_data : lsb_head;
`else
    assign alu_cand      = !alu_empty;
    assign lsb_cand      = !lsb_empty;
    assign alu_cand_data = alu_head;
    assign lsb_cand_data = lsb_head;
`endif

    // Round-robin arbitration: rr_q names the source preferred on a tie and
    // always points at the loser of the last grant.
    always_comb begin
        lsb_grant = lsb_cand && (!alu_cand || (rr_q == CDB_SRC_LSB));
        alu_grant = alu_cand && !lsb_grant;
        rr_d      = rr_q;
        if (alu_grant) begin
            rr_d = CDB_SRC_LSB;
        end else if (lsb_grant) begin
            rr_d = CDB_SRC_ALU;
        end
    end

    // A granted result that came through the bypass never enters the FIFO;
    // every other accepted input is queued. Nothing moves while rdy is low.
    always_comb begin
        alu_push = rdy && alu_in_ok && !(alu_grant && alu_empty);
        lsb_push = rdy && lsb_in_ok && !(lsb_grant && lsb_empty);
        alu_pop  = rdy && alu_grant && !alu_empty;
        lsb_pop  = rdy && lsb_grant && !lsb_empty;
    end

    // Next broadcast: winner's payload, or an all-zero idle bus.
    always_comb begin
        win_data     = '0;
        cdb_valid_d  = 1'b0;
        cdb_src_d    = CDB_SRC_ALU;
        if (alu_grant) begin
            win_data    = alu_cand_data;
            cdb_valid_d = 1'b1;
            cdb_src_d   = CDB_SRC_ALU;
        end else if (lsb_grant) begin
            win_data    = lsb_cand_data;
            cdb_valid_d = 1'b1;
            cdb_src_d   = CDB_SRC_LSB;
        end
        cdb_res_d    = win_data[W-1:ROB_ID_W];
        cdb_rob_id_d = win_data[ROB_ID_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_q         <= CDB_SRC_ALU;
            cdb_valid_q  <= 1'b0;
            cdb_res_q    <= '0;
            cdb_rob_id_q <= '0;
            cdb_src_q    <= 1'b0;
        end else if (rdy) begin
            rr_q         <= rr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_res_q    <= cdb_res_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (alu_push),
        .pop       (alu_pop),
        .push_data (alu_in_data),
        .head      (alu_head),
        .count     (alu_count)
    );

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (lsb_push),
        .pop       (lsb_pop),
        .push_data (lsb_in_data),
        .head      (lsb_head),
        .count     (lsb_count)
    );

    // One free slot of slack covers a result the producer already issued.
    assign alu_afull  = (alu_count >= CNT_W'(FIFO_DEPTH - 1));
    assign lsb_afull  = (lsb_count >= CNT_W'(FIFO_DEPTH - 1));

    assign cdb_valid  = cdb_valid_q;
    assign cdb_res    = cdb_res_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter. Expected broadcasts are
// written out by hand for both builds (with and without CDB_BYPASS_EN).
module tb_cdb_arbiter;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy = 1'b1;
    logic          flush = 1'b0;
    logic          alu_valid = 1'b0;
    logic [31:0]   alu_res = '0;
    logic [RW-1:0] alu_rob_id = '0;
    logic          lsb_valid = 1'b0;
    logic [31:0]   lsb_res = '0;
    logic [RW-1:0] lsb_rob_id = '0;
    logic          alu_afull, lsb_afull;
    logic          cdb_valid;
    logic [31:0]   cdb_res;
    logic [RW-1:0] cdb_rob_id;
    logic          cdb_src;

    int vectors = 0;
    int miscompares = 0;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_res    (alu_res),
        .alu_rob_id (alu_rob_id),
        .lsb_valid  (lsb_valid),
        .lsb_res    (lsb_res),
        .lsb_rob_id (lsb_rob_id),
        .alu_afull  (alu_afull),
        .lsb_afull  (lsb_afull),
        .cdb_valid  (cdb_valid),
        .cdb_res    (cdb_res),
        .cdb_rob_id (cdb_rob_id),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    // Packs a broadcast as {valid, res, tag, src} for single-shot comparison.
    function automatic logic [63:0] cdbWord(input logic v, input logic [31:0] r,
                                            input logic [RW-1:0] id, input logic s);
        return {25'b0, v, r, id, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkCdb(input string tag, input logic [63:0] exp);
        checkOutput(tag, cdbWord(cdb_valid, cdb_res, cdb_rob_id, cdb_src), exp);
    endtask

    // Drives both producer inputs, advances one clock and settles past the edge.
    task automatic applyStimulus(input logic av, input logic [31:0] ar, input logic [RW-1:0] ai,
                                 input logic lv, input logic [31:0] lr, input logic [RW-1:0] li);
        alu_valid  = av;
        alu_res    = ar;
        alu_rob_id = ai;
        lsb_valid  = lv;
        lsb_res    = lr;
        lsb_rob_id = li;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, '0, 1'b0, 32'h0, '0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
    endtask

    initial begin
        int aq[$];
        int lq[$];
        int n_issued;
        int n_recv;
        int fill_cycles;
        int exp_tag;
        logic last_src;
        logic have_last;
        logic afull_seen;
        logic av, lv;
        logic [RW-1:0] ai, li;

        $display("[TB] cdb_arbiter directed bench");

        // Reset and idle
        doReset();
        checkCdb("reset_cdb", 64'h0);
        checkOutput("reset_afull", {alu_afull, lsb_afull}, 64'h0);
        idleCycle();
        checkCdb("idle_cdb", 64'h0);

        // Single uncontended ALU result
        applyStimulus(1'b1, 32'h1234, 5'd5, 1'b0, 32'h0, '0);
`ifdef CDB_BYPASS_EN
        checkCdb("alu_only_n1", cdbWord(1'b1, 32'h1234, 5'd5, 1'b0));
        idleCycle();
        checkCdb("alu_only_n2", 64'h0);
`else
        checkCdb("alu_only_n1", 64'h0);
        idleCycle();
        checkCdb("alu_only_n2", cdbWord(1'b1, 32'h1234, 5'd5, 1'b0));
        idleCycle();
        checkCdb("alu_only_n3", 64'h0);
`endif

        // Simultaneous results with rr at ALU, then again to show rr returned to ALU
        doReset();
        applyStimulus(1'b1, 32'hA3, 5'd3, 1'b1, 32'hB7, 5'd7);
`ifdef CDB_BYPASS_EN
        checkCdb("tie_alu_first", cdbWord(1'b1, 32'hA3, 5'd3, 1'b0));
        idleCycle();
        checkCdb("tie_lsb_second", cdbWord(1'b1, 32'hB7, 5'd7, 1'b1));
        applyStimulus(1'b1, 32'hA4, 5'd4, 1'b1, 32'hB8, 5'd8);
        checkCdb("tie2_alu_first", cdbWord(1'b1, 32'hA4, 5'd4, 1'b0));
        idleCycle();
        checkCdb("tie2_lsb_second", cdbWord(1'b1, 32'hB8, 5'd8, 1'b1));
`else
        checkCdb("tie_queued", 64'h0);
        idleCycle();
        checkCdb("tie_alu_first", cdbWord(1'b1, 32'hA3, 5'd3, 1'b0));
        idleCycle();
        checkCdb("tie_lsb_second", cdbWord(1'b1, 32'hB7, 5'd7, 1'b1));
        applyStimulus(1'b1, 32'hA4, 5'd4, 1'b1, 32'hB8, 5'd8);
        checkCdb("tie2_queued", 64'h0);
        idleCycle();
        checkCdb("tie2_alu_first", cdbWord(1'b1, 32'hA4, 5'd4, 1'b0));
        idleCycle();
        checkCdb("tie2_lsb_second", cdbWord(1'b1, 32'hB8, 5'd8, 1'b1));
`endif
        idleCycle();
        checkCdb("tie_drained", 64'h0);

        // Both producers saturated for 8 cycles, honouring afull, then drain.
        // Queues hold issued tags not yet seen on the bus.
        doReset();
        n_issued   = 0;
        n_recv     = 0;
        have_last  = 1'b0;
        last_src   = 1'b0;
        afull_seen = 1'b0;
        ai = 5'd1;
        li = 5'd16;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (alu_afull || lsb_afull) afull_seen = 1'b1;
            av = (cyc < 8) && !alu_afull;
            lv = (cyc < 8) && !lsb_afull;
            applyStimulus(av, 32'h100 + 32'(ai), ai, lv, 32'h200 + 32'(li), li);
            if (av) begin aq.push_back(int'(ai)); ai++; n_issued++; end
            if (lv) begin lq.push_back(int'(li)); li++; n_issued++; end
            if (cdb_valid) begin
                if (have_last && aq.size() >= 2 && lq.size() >= 2)
                    checkOutput("sat_alternate", 64'(cdb_src), 64'(!last_src));
                if (cdb_src == 1'b0) begin
                    exp_tag = (aq.size() > 0) ? aq.pop_front() : 0;
                    checkOutput("sat_alu_order", {cdb_res, 27'b0, cdb_rob_id},
                                {32'h100 + 32'(exp_tag), 27'b0, 5'(exp_tag)});
                end else begin
                    exp_tag = (lq.size() > 0) ? lq.pop_front() : 0;
                    checkOutput("sat_lsb_order", {cdb_res, 27'b0, cdb_rob_id},
                                {32'h200 + 32'(exp_tag), 27'b0, 5'(exp_tag)});
                end
                last_src  = cdb_src;
                have_last = 1'b1;
                n_recv++;
            end
        end
        checkOutput("sat_afull_seen", 64'(afull_seen), 64'h1);
        checkOutput("sat_no_drop", 64'(aq.size() + lq.size()), 64'h0);
        checkOutput("sat_recv_count", 64'(n_recv), 64'(n_issued));
        checkOutput("sat_afull_clear", {alu_afull, lsb_afull}, 64'h0);

        // Reset mid-stream with the LSB FIFO holding 3 entries
`ifdef CDB_BYPASS_EN
        fill_cycles = 5;
`else
        fill_cycles = 4;
`endif
        doReset();
        for (int i = 0; i < fill_cycles; i++)
            applyStimulus(1'b1, 32'h300 + 32'(i), 5'(1 + i), 1'b1, 32'h400 + 32'(i), 5'(16 + i));
        checkOutput("pre_rst_lsb_afull", 64'(lsb_afull), 64'h1);
        doReset();
        checkCdb("mid_rst_cdb", 64'h0);
        checkOutput("mid_rst_afull", {alu_afull, lsb_afull}, 64'h0);
        idleCycle();
        checkCdb("mid_rst_empty", 64'h0);

        // Flush with two entries in each FIFO and valid inputs in the flush cycle
        doReset();
        for (int i = 0; i < fill_cycles - 1; i++)
            applyStimulus(1'b1, 32'h500 + 32'(i), 5'(1 + i), 1'b1, 32'h600 + 32'(i), 5'(16 + i));
        flush = 1'b1;
        applyStimulus(1'b1, 32'h5FF, 5'd30, 1'b1, 32'h6FF, 5'd31);
        flush = 1'b0;
        checkCdb("flush_cdb", 64'h0);
        checkOutput("flush_afull", {alu_afull, lsb_afull}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkCdb("flush_nothing_left", 64'h0);
        end
        applyStimulus(1'b1, 32'hC0DE, 5'd12, 1'b0, 32'h0, '0);
`ifndef CDB_BYPASS_EN
        idleCycle();
`endif
        checkCdb("post_flush_alu", cdbWord(1'b1, 32'hC0DE, 5'd12, 1'b0));

        // rdy low for three cycles with a pending LSB result
        doReset();
        applyStimulus(1'b1, 32'h99, 5'd9, 1'b1, 32'hAA, 5'd10);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hBB, 5'd11, 1'b0, 32'h0, '0);
`ifdef CDB_BYPASS_EN
            checkCdb("rdy_low_hold", cdbWord(1'b1, 32'h99, 5'd9, 1'b0));
`else
            checkCdb("rdy_low_hold", 64'h0);
`endif
        end
        rdy = 1'b1;
`ifndef CDB_BYPASS_EN
        idleCycle();
        checkCdb("rdy_back_alu", cdbWord(1'b1, 32'h99, 5'd9, 1'b0));
`endif
        idleCycle();
        checkCdb("rdy_back_lsb", cdbWord(1'b1, 32'hAA, 5'd10, 1'b1));
        idleCycle();
        checkCdb("rdy_input_ignored", 64'h0);

        // Valid with tag 0 never broadcasts
        applyStimulus(1'b1, 32'h55, 5'd0, 1'b0, 32'h0, '0);
        checkCdb("tag0_n1", 64'h0);
        idleCycle();
        checkCdb("tag0_n2", 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
